spi_master_xfer: RTL and testbench
==================================

SPI_MASTER_XFER -- requirements
Module: spi_master_xfer

Interface
REQ-001 Parameter DATA_W, default 8, bits per transfer (legal 4..32).
REQ-002 Parameter DIV_W, default 8, width of the clk_div input.
REQ-003 Parameter NUM_CS, default 1, number of chip-select lines (legal 1..8).
REQ-004 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  one-cycle request; honoured only while busy=0.
REQ-007 Port tx_data  input  DATA_W  word to send, MSB first; latched at start.
REQ-008 Port mode  input  2  {CPOL,CPHA}; latched at start.
REQ-009 Port clk_div  input  DIV_W  half-period of SCK in clk cycles, minus 1; latched at start.
REQ-010 Port cs_sel  input  $clog2(NUM_CS) (min 1)  chip-select index; latched at start.
REQ-011 Port cs_hold  input  1  keep CS asserted after this transfer; latched at start.
REQ-012 Port miso  input  1  serial data from slave.
REQ-013 Port sck  output  1  SPI clock.
REQ-014 Port mosi  output  1  serial data to slave.
REQ-015 Port cs_n  output  NUM_CS  active-low chip selects.
REQ-016 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-017 Port done  output  1  one-cycle pulse; rx_data valid in that cycle.
REQ-018 Port rx_data  output  DATA_W  received word; holds until the next done.

Function
REQ-019 States SHALL be IDLE, LEAD, XFER, TRAIL, DONE. Below, H = clk_div+1 (latched).
REQ-020 IDLE->LEAD on start=1 with busy=0; tx_data, mode, clk_div, cs_sel and cs_hold SHALL be latched on that edge.
REQ-021 LEAD SHALL last H cycles, with cs_n[cs_sel]=0, sck=CPOL and mosi=tx MSB when CPHA=0.
REQ-022 XFER SHALL produce DATA_W SCK periods, each 2H cycles; sck toggles every H cycles, starting from CPOL.
REQ-023 CPHA=0: miso sampled on each leading edge; mosi updated on each trailing edge except the last.
REQ-024 CPHA=1: mosi updated on each leading edge; miso sampled on each trailing edge.
REQ-025 Received bits SHALL shift in MSB first; the first sampled bit becomes rx_data[DATA_W-1].
REQ-026 TRAIL SHALL last H cycles with sck=CPOL; DONE SHALL last 1 cycle, assert done and update rx_data, then return to IDLE.
REQ-027 Latency: if start is accepted at edge k, done SHALL be high in the cycle after edge k+H*(2*DATA_W+2).
REQ-028 busy SHALL be 1 in LEAD, XFER, TRAIL and DONE, and 0 in IDLE.
REQ-029 start while busy=1 SHALL be ignored without side effect, including a start coincident with done.
REQ-030 cs_hold=1: cs_n[cs_sel] SHALL stay 0 after DONE; cs_hold=0: all cs_n SHALL be 1 from the DONE cycle onward.
REQ-031 A start selecting a different index while CS is held SHALL release the old line in the same cycle the new one asserts.
REQ-032 clk_div=0 (H=1) SHALL be legal; the maximum clk_div SHALL not overflow the internal divider counter.
REQ-033 Input changes during busy SHALL NOT affect the transfer in progress.
REQ-034 In IDLE, sck SHALL equal the CPOL of the last accepted transfer (0 after reset), and mosi SHALL be 1.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, sck=0, mosi=1, cs_n all 1, busy=0, done=0 and rx_data=0, regardless of clk.
REQ-036 Reset asserted mid-transfer SHALL abort the transfer with no done pulse; the first start after release SHALL behave normally.

Verification
REQ-037 Mode 0, clk_div=1, DATA_W=8, tx_data=0xA5, miso looped to mosi -> 8 rising sck edges, rx_data=0xA5, done 37 cycles after start.
REQ-038 Mode 3, clk_div=0, tx_data=0x3C, slave returns 0xC3 -> sck idles high, mosi changes on falling edges, rx_data=0xC3, done 19 cycles after start.
REQ-039 NUM_CS=4, cs_sel=2: first transfer with cs_hold=1, then 0x40 with cs_hold=0 -> cs_n=4'b1011 continuously between the two transfers, then 4'b1111 from the second done.
REQ-040 start pulsed at cycles 3 and 10 of a 37-cycle transfer -> exactly one done, and no restart.
REQ-041 reset asserted at bit 4 of a transfer -> all outputs at reset values asynchronously; the next transfer of 0x5A returns the correct rx_data.
REQ-042 clk_div changes from 124 to 1 between transfers -> first transfer has SCK half-period 125 cycles, second has 2.

Source files
------------

// File: rtl/spi_master_xfer_if.sv
// Host-side control/status and SPI pin bundle for spi_master_xfer.
// The DUT uses the slave modport; the host/bench side uses master.
interface spi_master_xfer_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [1:0]        mode;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic              cs_hold;
    logic              miso;
    logic              sck;
    logic              mosi;
    logic [NUM_CS-1:0] cs_n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;

    modport slave (
        input  start, tx_data, mode, clk_div, cs_sel, cs_hold, miso,
        output sck, mosi, cs_n, busy, done, rx_data
    );

    modport master (
        output start, tx_data, mode, clk_div, cs_sel, cs_hold, miso,
        input  sck, mosi, cs_n, busy, done, rx_data
    );
endinterface

// File: rtl/spi_master_xfer.sv
// Single-word SPI master: programmable SCK divider, all four modes,
// multiple chip selects with optional CS hold between transfers.
module spi_master_xfer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int NUM_CS = 1
) (
    input logic clk,
    input logic reset,
    spi_master_xfer_if.slave bus
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int EW   = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_E = EW'(2 * DATA_W - 1);
    localparam logic [EW-1:0] END_E  = EW'(2 * DATA_W);

    typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;

    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [EW-1:0]     r_edge;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_cpha;
    logic              r_hold;
    logic              r_sck;
    logic              r_mosi;
    logic              r_busy;
    logic              r_done;
    logic [NUM_CS-1:0] r_cs_n;

    logic w_tick;
    logic w_lead;
    logic w_smp;
    logic w_upd;
    logic w_fire;

    function automatic logic [NUM_CS-1:0] sel_n(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (CS_W'(i) == sel) m[i] = 1'b0;
        end
        return m;
    endfunction

    // Edge j of the burst: even j is a leading edge, odd j a trailing edge.
    assign w_tick = (r_cnt == r_div);
    assign w_lead = ~r_edge[0];
    assign w_smp  = r_cpha ? ~w_lead : w_lead;
    assign w_upd  = r_cpha ? w_lead : (~w_lead && (r_edge != LAST_E));
    assign w_fire = w_tick && ((r_state == LEAD) ||
                    ((r_state == XFER) && (r_edge != END_E)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_cpha    <= 1'b0;
            r_hold    <= 1'b0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cs_n    <= '1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= LEAD;
                        r_busy  <= 1'b1;
                        r_div   <= bus.clk_div;
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_cpha  <= bus.mode[0];
                        r_hold  <= bus.cs_hold;
                        r_sck   <= bus.mode[1];
                        r_cs_n  <= sel_n(bus.cs_sel);
                        r_mosi  <= bus.mode[0] ? 1'b1 : bus.tx_data[DATA_W-1];
                        r_tx    <= bus.mode[0] ? bus.tx_data : (bus.tx_data << 1);
                    end
                end
                LEAD: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) r_state <= XFER;
                end
                XFER: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick && (r_edge == END_E)) r_state <= TRAIL;
                end
                TRAIL: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        r_mosi    <= 1'b1;
                        if (!r_hold) r_cs_n <= '1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase

            if (w_fire) begin
                r_sck  <= ~r_sck;
                r_edge <= r_edge + 1'b1;
                if (w_smp) r_rx <= {r_rx[DATA_W-2:0], bus.miso};
                if (w_upd) begin
                    r_mosi <= r_tx[DATA_W-1];
                    r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.sck     = r_sck;
    assign bus.mosi    = r_mosi;
    assign bus.cs_n    = r_cs_n;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
endmodule

// File: tb/tb_spi_master_xfer.sv
// Randomised scoreboard bench for spi_master_xfer with a behavioural
// SPI slave that returns a chosen word and captures what it receives.
module tb_spi_master_xfer;
    localparam int DW = 8;
    localparam int VW = 8;
    localparam int NC = 4;
    localparam int CW = 2;

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] tx;
        longint        done_cyc;
        int            h;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_master_xfer_if #(.DATA_W(DW), .DIV_W(VW), .NUM_CS(NC)) bus ();

    spi_master_xfer #(.DATA_W(DW), .DIV_W(VW), .NUM_CS(NC)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;

    logic [DW-1:0] s_word = '0;
    logic          s_cpol = 1'b0;
    logic          s_cpha = 1'b0;
    logic          s_en = 1'b0;
    int            arm_cnt = 0;
    logic [DW-1:0] s_cap;
    int            s_nl;
    int            s_half;
    longint        s_t1;

    logic [NC-1:0] cs_exp = '1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // SPI slave: leading edge = SCK leaving CPOL. Edges before the first
    // leading edge (CPOL changes at transfer start) are ignored.
    initial begin
        int seen;
        seen = 0;
        bus.miso = 1'b0;
        s_nl = 0;
        s_half = -1;
        s_cap = '0;
        s_t1 = 0;
        forever begin
            @(bus.sck or arm_cnt);
            if (arm_cnt != seen) begin
                seen = arm_cnt;
                s_nl = 0;
                s_half = -1;
                s_cap = '0;
                bus.miso = s_cpha ? 1'b0 : s_word[DW-1];
            end else if (s_en) begin
                if (bus.sck != s_cpol) begin
                    if (s_cpha) begin
                        if (s_nl < DW) bus.miso = s_word[DW-1-s_nl];
                    end else begin
                        s_cap = {s_cap[DW-2:0], bus.mosi};
                    end
                    if (s_nl == 0) s_t1 = $time;
                    s_nl++;
                end else if (s_nl > 0) begin
                    if (s_cpha) s_cap = {s_cap[DW-2:0], bus.mosi};
                    else if (s_nl < DW) bus.miso = s_word[DW-1-s_nl];
                    if (s_nl == 1 && s_half < 0)
                        s_half = int'(($time - s_t1) / 10);
                end
            end
        end
    end

    // Monitor: every done pulse consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", bus.rx_data, e.rx);
                    chk("latency", cyc, e.done_cyc);
                    chk("mosi_word", s_cap, e.tx);
                    chk("lead_edges", s_nl, DW);
                    chk("half_period", s_half, e.h);
                end
            end
        end
    end

    task automatic arm(input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                       input logic [1:0] md, input logic [VW-1:0] dv,
                       input logic [CW-1:0] sel, input logic hold);
        s_word = sw;
        s_cpol = md[1];
        s_cpha = md[0];
        s_en = 1'b1;
        arm_cnt++;
        bus.tx_data = tx;
        bus.mode = md;
        bus.clk_div = dv;
        bus.cs_sel = sel;
        bus.cs_hold = hold;
        bus.start = 1'b1;
    endtask

    task automatic xfer(input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                        input logic [1:0] md, input logic [VW-1:0] dv,
                        input logic [CW-1:0] sel, input logic hold);
        exp_t e;
        int n;
        int bound;
        arm(tx, sw, md, dv, sel, hold);
        e.rx = sw;
        e.tx = tx;
        e.h = int'(dv) + 1;
        e.done_cyc = cyc + 1 + longint'(e.h) * (2 * DW + 2);
        sb.push_back(e);
        cs_exp = ~(NC'(1) << sel);
        bound = 2 * e.h * (2 * DW + 2) + 8;
        @(negedge clk);
        chk("busy_set", bus.busy, 1'b1);
        n = 0;
        // Junk on every input while busy, plus stray start pulses.
        while (bus.busy && n < bound) begin
            if (bus.done && !hold) cs_exp = '1;
            chk("cs_n_busy", bus.cs_n, cs_exp);
            bus.tx_data = DW'($urandom);
            bus.mode = 2'($urandom);
            bus.clk_div = VW'($urandom);
            bus.cs_sel = CW'($urandom);
            bus.cs_hold = 1'($urandom);
            bus.start = (n == 2 || n == 9 || $urandom_range(0, 7) == 0);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        if (n >= bound) chk("busy_timeout", 64'd1, 64'd0);
        chk("idle_sck", bus.sck, md[1]);
        chk("idle_mosi", bus.mosi, 1'b1);
        repeat ($urandom_range(0, 3)) begin
            chk("idle_cs_n", bus.cs_n, cs_exp);
            @(negedge clk);
        end
        chk("idle_cs_n", bus.cs_n, cs_exp);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.tx_data = '0;
        bus.mode = 2'b00;
        bus.clk_div = '0;
        bus.cs_sel = '0;
        bus.cs_hold = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sck", bus.sck, 1'b0);
        chk("rst_mosi", bus.mosi, 1'b1);
        chk("rst_cs_n", bus.cs_n, 4'hF);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_rx", bus.rx_data, 8'h00);
        reset = 1'b1;
        @(negedge clk);

        xfer(8'hA5, 8'hA5, 2'b00, 8'd1, 2'd0, 1'b0);
        xfer(8'h3C, 8'hC3, 2'b11, 8'd0, 2'd0, 1'b0);
        xfer(DW'($urandom), DW'($urandom), 2'b00, 8'd1, 2'd2, 1'b1);
        xfer(8'h40, DW'($urandom), 2'b01, 8'd1, 2'd2, 1'b0);
        xfer(DW'($urandom), DW'($urandom), 2'b10, 8'd2, 2'd1, 1'b1);
        xfer(DW'($urandom), DW'($urandom), 2'b11, 8'd0, 2'd3, 1'b0);
        xfer(DW'($urandom), DW'($urandom), 2'b00, 8'd124, 2'd0, 1'b0);
        xfer(DW'($urandom), DW'($urandom), 2'b00, 8'd1, 2'd0, 1'b0);
        xfer(8'h81, 8'hC3, 2'b00, 8'd0, 2'd0, 1'b1);

        // Abort mid-transfer around bit 4 with an asynchronous reset.
        arm(8'h96, 8'h69, 2'b11, 8'd2, 2'd1, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3 * 9 - 1) @(negedge clk);
        #2;
        s_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort_sck", bus.sck, 1'b0);
        chk("abort_mosi", bus.mosi, 1'b1);
        chk("abort_cs_n", bus.cs_n, 4'hF);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_rx", bus.rx_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cs_exp = '1;
        @(negedge clk);
        xfer(8'h5A, 8'h5A, 2'b00, 8'd1, 2'd0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            xfer(DW'($urandom), DW'($urandom), 2'($urandom),
                 VW'($urandom_range(0, 4)), CW'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
